// File: rtl/rr_arbiter_3x8_sched_pkg.sv
// Shared types and helpers for the 8-way round-robin decoder-select arbiter.
// Combinational helpers only; no latency, no backpressure.
package rr_arbiter_3x8_sched_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    // Decoder mapping: index 0 lights bit 7; for a 3-bit index, 7-idx is ~idx.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[~idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter_3x8_sched_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Wires only; no latency, no backpressure.
interface rr_arbiter_3x8_sched_if;
    import rr_arbiter_3x8_sched_pkg::*;

    logic             arb_en;
    logic [N_REQ-1:0] req;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_onehot;
    logic             timeout;

    modport master (
        output arb_en, req,
        input  gnt_valid, gnt_idx, gnt_onehot, timeout
    );

    modport slave (
        input  arb_en, req,
        output gnt_valid, gnt_idx, gnt_onehot, timeout
    );

endinterface

// File: rtl/rr_arbiter_3x8_sched_pick.sv
// Round-robin scan: first set request at or after ptr, wrapping 7 -> 0.
// Purely combinational; no backpressure.
module rr_pick_8
    import rr_arbiter_3x8_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_3x8_sched.sv
// 8-way round-robin arbiter driving a 3x8 decoder select, with hold timeout.
// Grant registered 1 cycle after request; one dead cycle between grants; requests are not queued.
module rr_arbiter_3x8_sched
    import rr_arbiter_3x8_sched_pkg::*;
#(
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_arbiter_3x8_sched_if.slave   bus
);

    localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic [N_REQ-1:0] onehot_q, onehot_d;
    logic             timeout_q, timeout_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             arb_ok;
    logic             req_kept;
    logic             hold_expired;

    rr_pick_8 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (win_found),
        .idx   (win_idx)
    );

    assign arb_ok       = bus.arb_en && win_found;
    assign req_kept     = bus.req[idx_q];
    assign hold_expired = TIMEOUT_EN && (hold_q == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            onehot_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                hold_d = '0;
                if (arb_ok) begin
                    state_d = ST_GRANT;
                    idx_d   = win_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                // A dropped request wins over an expiring hold, so no timeout pulse then.
                if (!req_kept || hold_expired) begin
                    state_d = ST_RELEASE;
                    ptr_d   = idx_q + IDX_W'(1);
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        valid_d   = (state_d == ST_GRANT);
        onehot_d  = valid_d ? idx_to_onehot(idx_d) : '0;
        timeout_d = (state_q == ST_GRANT) && req_kept && hold_expired;
    end

    assign bus.gnt_valid  = valid_q;
    assign bus.gnt_idx    = idx_q;
    assign bus.gnt_onehot = onehot_q;
    assign bus.timeout    = timeout_q;

endmodule
